// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit frame controller: start, DATA_W data bits LSB first,
// optional parity, one or two stop bits; ready/valid input, baud-tick advance.
// Ports: CLK, RST (sync, active-high), TICK, P_DATA/DATA_VALID/DATA_READY,
//   PAR_EN, PAR_TYP, STOP2, TX_OUT (registered), BUSY, FRAME_DONE.
// Optional: define UART_TX_BREAK_EN to add BREAK_REQ and a line-break state.
module uart_tx_frame_ctrl #(
  parameter int DATA_W    = 8,
  parameter int TICK_SYNC = 1
) (
  input  logic              CLK,
  input  logic              RST,
`ifdef UART_TX_BREAK_EN
  input  logic              BREAK_REQ,
`endif
  input  logic              TICK,
  input  logic [DATA_W-1:0] P_DATA,
  input  logic              DATA_VALID,
  output logic              DATA_READY,
  input  logic              PAR_EN,
  input  logic              PAR_TYP,
  input  logic              STOP2,
  output logic              TX_OUT,
  output logic              BUSY,
  output logic              FRAME_DONE
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam int BRK_W = $clog2(DATA_W + 3);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
`ifdef UART_TX_BREAK_EN
    , ST_BREAK,
    ST_MARK
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               par_q, par_d;
  logic               pen_q, pen_d;
  logic               stop2_q, stop2_d;
  logic               stop_cnt_q, stop_cnt_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;
`ifdef UART_TX_BREAK_EN
  logic [BRK_W-1:0]   brk_cnt_q, brk_cnt_d;
`endif

  logic adv;
  logic last_stop;
  logic idle_rdy;
  logic xfer;

  assign adv = (TICK_SYNC != 0) ? TICK : 1'b1;

  // Final stop period ends on this adv.
  assign last_stop = (state_q == ST_STOP) & adv &
                     (stop2_q ? stop_cnt_q : 1'b1);

`ifdef UART_TX_BREAK_EN
  assign idle_rdy = (state_q == ST_IDLE) & ~BREAK_REQ;
`else
  assign idle_rdy = (state_q == ST_IDLE);
`endif

  assign DATA_READY = ~RST & (idle_rdy | last_stop);
  assign FRAME_DONE = ~RST & last_stop;
  assign xfer       = DATA_VALID & DATA_READY;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    par_d      = par_q;
    pen_d      = pen_q;
    stop2_d    = stop2_q;
    stop_cnt_d = stop_cnt_q;
`ifdef UART_TX_BREAK_EN
    brk_cnt_d  = brk_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
`ifdef UART_TX_BREAK_EN
        if (BREAK_REQ) begin
          state_d   = ST_BREAK;
          brk_cnt_d = '0;
        end
`endif
      end
      ST_START: begin
        if (adv) begin
          state_d = ST_DATA;
          cnt_d   = '0;
        end
      end
      ST_DATA: begin
        if (adv) begin
          shift_d = shift_q >> 1;
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d    = pen_q ? ST_PARITY : ST_STOP;
            stop_cnt_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (adv) begin
          state_d    = ST_STOP;
          stop_cnt_d = 1'b0;
        end
      end
      ST_STOP: begin
        if (last_stop) begin
          state_d = ST_IDLE;
        end else if (adv) begin
          stop_cnt_d = 1'b1;
        end
      end
`ifdef UART_TX_BREAK_EN
      ST_BREAK: begin
        if (adv) begin
          if (brk_cnt_q == BRK_W'(DATA_W + 2)) begin
            state_d = ST_MARK;
          end else begin
            brk_cnt_d = brk_cnt_q + BRK_W'(1);
          end
        end
      end
      ST_MARK: begin
        if (adv) begin
          state_d = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // New frame: in IDLE, or overlapping the last stop adv.
    if (xfer) begin
      state_d = ST_START;
      shift_d = P_DATA;
      par_d   = (^P_DATA) ^ PAR_TYP;
      pen_d   = PAR_EN;
      stop2_d = STOP2;
    end
  end

  // Line level follows the state being entered so it is aligned
  // with the state register.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      ST_IDLE:   tx_d = 1'b1;
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_d;
      ST_STOP:   tx_d = 1'b1;
`ifdef UART_TX_BREAK_EN
      ST_BREAK:  tx_d = 1'b0;
      ST_MARK:   tx_d = 1'b1;
`endif
      default:   tx_d = 1'b1;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      par_q      <= 1'b0;
      pen_q      <= 1'b0;
      stop2_q    <= 1'b0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
`ifdef UART_TX_BREAK_EN
      brk_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      par_q      <= par_d;
      pen_q      <= pen_d;
      stop2_q    <= stop2_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
`ifdef UART_TX_BREAK_EN
      brk_cnt_q  <= brk_cnt_d;
`endif
    end
  end

  assign TX_OUT = tx_q;
  assign BUSY   = busy_q;

endmodule
